// File: rtl/mem_ctrl.sv
// mem_ctrl: MEM-stage load/store sequencer running req/ack bus transactions with stall, write-back and error pulse
//   clk, rst             : clock, asynchronous active-high reset
//   i_mem_op/addr/wdata  : access request from ex_mem (01 load, 10 store, 00/11 none)
//   i_w_reg_addr, i_wd   : load destination and its write enable
//   bus_*                : data-memory req/ack bus
//   stall_req            : combinational pipeline hold
//   o_w_reg_data/addr, o_wd : load write-back, valid for the single DONE cycle
//   mem_err              : one-cycle pulse on misaligned access or bus timeout
module mem_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  i_mem_op,
  input  logic [31:0] i_mem_addr,
  input  logic [31:0] i_mem_wdata,
  input  logic [4:0]  i_w_reg_addr,
  input  logic        i_wd,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        stall_req,
  output logic [31:0] o_w_reg_data,
  output logic [4:0]  o_w_reg_addr,
  output logic        o_wd,
  output logic        mem_err
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, state_nx;
  logic [7:0] cnt;
  logic [4:0] rd_q;
  logic wd_q, valid, aligned, accept, last;
  assign valid   = i_mem_op == 2'b01 || i_mem_op == 2'b10;
  assign aligned = i_mem_addr[1:0] == 2'b00;
  assign accept  = state == IDLE && valid && aligned;
  // the counter holds the number of ACCESS cycles already spent without ack
  assign last    = cnt == 8'(TIMEOUT - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx  = IDLE;
    stall_req = 1'b0;
    state_nx  = state == IDLE ? (accept ? ACCESS : IDLE) :
                state == ACCESS ? (bus_ack || last ? DONE : ACCESS) : IDLE;
    stall_req = accept || state == ACCESS;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= 32'h0;
      bus_wdata    <= 32'h0;
      rd_q         <= 5'h0;
      wd_q         <= 1'b0;
      cnt          <= 8'd0;
      o_wd         <= 1'b0;
      o_w_reg_data <= 32'h0;
      o_w_reg_addr <= 5'h0;
      mem_err      <= 1'b0;
    end else begin
      bus_req      <= state_nx == ACCESS;
      cnt          <= state == ACCESS ? cnt + 8'd1 : 8'd0;
      // ack on the final counted cycle is a success, so timeout needs !bus_ack
      mem_err      <= (state == IDLE && valid && !aligned) || (state == ACCESS && !bus_ack && last);
      o_wd         <= state == ACCESS && bus_ack && wd_q && !bus_we;
      o_w_reg_data <= state == ACCESS && bus_ack ? bus_rdata : 32'h0;
      o_w_reg_addr <= state == ACCESS && state_nx == DONE ? rd_q : 5'h0;
      if (accept) begin
        bus_we    <= i_mem_op[1];
        bus_addr  <= i_mem_addr;
        bus_wdata <= i_mem_wdata;
        rd_q      <= i_w_reg_addr;
        wd_q      <= i_wd;
      end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed self-checking bench for mem_ctrl
module tb_mem_ctrl;
  logic        clk = 1'b0, rst = 1'b0;
  logic [1:0]  i_mem_op = 2'b00;
  logic [31:0] i_mem_addr = 32'h0, i_mem_wdata = 32'h0;
  logic [4:0]  i_w_reg_addr = 5'h0;
  logic        i_wd = 1'b0;
  logic        bus_req, bus_we, bus_ack = 1'b0;
  logic [31:0] bus_addr, bus_wdata, bus_rdata = 32'h0;
  logic        stall_req, o_wd, mem_err;
  logic [31:0] o_w_reg_data;
  logic [4:0]  o_w_reg_addr;
  int n_cmp = 0, n_err = 0;

  mem_ctrl #(.TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .i_mem_op(i_mem_op), .i_mem_addr(i_mem_addr),
    .i_mem_wdata(i_mem_wdata), .i_w_reg_addr(i_w_reg_addr), .i_wd(i_wd),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .stall_req(stall_req),
    .o_w_reg_data(o_w_reg_data), .o_w_reg_addr(o_w_reg_addr), .o_wd(o_wd), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // one transaction from the IDLE accept cycle through DONE and back to IDLE;
  // ack_at = ACCESS cycle carrying the ack (0 = never)
  task automatic xfer(input string tag, input logic [1:0] op, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [4:0] rd, input logic wd,
                      input int ack_at, input logic [31:0] rdata, input int exp_stall,
                      input int exp_req, input logic exp_wd, input logic exp_err);
    int stalls, reqs;
    stalls = 0;
    reqs = 0;
    i_mem_op = op; i_mem_addr = addr; i_mem_wdata = wdata; i_w_reg_addr = rd; i_wd = wd;
    #1;
    if (stall_req) stalls++;
    step();
    i_mem_op = 2'b00; i_mem_addr = 32'h0; i_mem_wdata = 32'h0; i_w_reg_addr = 5'h0; i_wd = 1'b0;
    while (bus_req && reqs < 300) begin
      reqs++;
      if (stall_req) stalls++;
      check({tag, ".we"}, {31'h0, bus_we}, {31'h0, op == 2'b10});
      check({tag, ".addr"}, bus_addr, addr);
      if (op == 2'b10) check({tag, ".wdata"}, bus_wdata, wdata);
      bus_ack = reqs == ack_at;
      bus_rdata = reqs == ack_at ? rdata : 32'hBAD0BAD0;
      step();
      bus_ack = 1'b0;
    end
    check({tag, ".stall_cycles"}, stalls, exp_stall);
    check({tag, ".req_cycles"}, reqs, exp_req);
    check({tag, ".done_stall"}, {31'h0, stall_req}, 32'h0);
    check({tag, ".done_wd"}, {31'h0, o_wd}, {31'h0, exp_wd});
    check({tag, ".done_err"}, {31'h0, mem_err}, {31'h0, exp_err});
    if (exp_wd) begin
      check({tag, ".done_rd"}, {27'h0, o_w_reg_addr}, {27'h0, rd});
      check({tag, ".done_data"}, o_w_reg_data, rdata);
    end
    step();
    check({tag, ".idle_wd"}, {31'h0, o_wd}, 32'h0);
    check({tag, ".idle_err"}, {31'h0, mem_err}, 32'h0);
    check({tag, ".idle_data"}, o_w_reg_data, 32'h0);
    check({tag, ".idle_req"}, {31'h0, bus_req}, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    #12;
    check("rst.req", {31'h0, bus_req}, 32'h0);
    check("rst.stall", {31'h0, stall_req}, 32'h0);
    check("rst.wd", {31'h0, o_wd}, 32'h0);
    check("rst.err", {31'h0, mem_err}, 32'h0);
    check("rst.addr", bus_addr, 32'h0);
    check("rst.data", o_w_reg_data, 32'h0);
    rst = 1'b0;
    step();
    xfer("load", 2'b01, 32'h100, 32'h0, 5'd5, 1'b1, 1, 32'hDEADBEEF, 2, 1, 1'b1, 1'b0);
    xfer("store", 2'b10, 32'h204, 32'h12345678, 5'd7, 1'b1, 4, 32'h0, 5, 4, 1'b0, 1'b0);
    xfer("timeout", 2'b01, 32'h300, 32'h0, 5'd9, 1'b1, 0, 32'h0, 16, 15, 1'b0, 1'b1);
    xfer("ack_last", 2'b01, 32'h304, 32'h0, 5'd11, 1'b1, 15, 32'hCAFEF00D, 16, 15, 1'b1, 1'b0);
    xfer("load_nowd", 2'b01, 32'h40, 32'h0, 5'd3, 1'b0, 2, 32'h55AA55AA, 3, 2, 1'b0, 1'b0);
    // misaligned load: no stall, error pulse one cycle later
    i_mem_op = 2'b01; i_mem_addr = 32'h102; i_w_reg_addr = 5'd4; i_wd = 1'b1;
    #1;
    check("misal.stall", {31'h0, stall_req}, 32'h0);
    step();
    i_mem_op = 2'b00; i_mem_addr = 32'h0;
    check("misal.req", {31'h0, bus_req}, 32'h0);
    check("misal.err", {31'h0, mem_err}, 32'h1);
    check("misal.wd", {31'h0, o_wd}, 32'h0);
    step();
    check("misal.err_clr", {31'h0, mem_err}, 32'h0);
    // reserved op does nothing
    i_mem_op = 2'b11; i_mem_addr = 32'h80;
    #1;
    check("rsvd.stall", {31'h0, stall_req}, 32'h0);
    step();
    i_mem_op = 2'b00; i_mem_addr = 32'h0;
    check("rsvd.req", {31'h0, bus_req}, 32'h0);
    check("rsvd.err", {31'h0, mem_err}, 32'h0);
    // reset during the second ACCESS cycle, then a late ack
    i_mem_op = 2'b01; i_mem_addr = 32'h500; i_w_reg_addr = 5'd6; i_wd = 1'b1;
    step();
    i_mem_op = 2'b00; i_mem_addr = 32'h0;
    step();
    check("mid.req_before", {31'h0, bus_req}, 32'h1);
    rst = 1'b1;
    #1;
    check("mid.req", {31'h0, bus_req}, 32'h0);
    check("mid.stall", {31'h0, stall_req}, 32'h0);
    check("mid.addr", bus_addr, 32'h0);
    check("mid.wd", {31'h0, o_wd}, 32'h0);
    #2;
    rst = 1'b0;
    step();
    bus_ack = 1'b1; bus_rdata = 32'h0BADF00D;
    step();
    bus_ack = 1'b0;
    check("late_ack.wd", {31'h0, o_wd}, 32'h0);
    check("late_ack.req", {31'h0, bus_req}, 32'h0);
    check("late_ack.data", o_w_reg_data, 32'h0);
    xfer("after_rst", 2'b01, 32'h600, 32'h0, 5'd12, 1'b1, 1, 32'h01234567, 2, 1, 1'b1, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
